// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI3 read channel among NREQ requesters.
// Exactly one burst is outstanding; the owner keeps the channel from AR handshake to RLAST.
module axi_rd_arbiter #(
  parameter int NREQ = 2,
  parameter int GW   = 1
) (
  input  logic                 bus_clk,
  input  logic                 bus_rst_n,
  input  logic [NREQ*32-1:0]   req_araddr,
  input  logic [NREQ*4-1:0]    req_arlen,
  input  logic [NREQ*3-1:0]    req_arsize,
  input  logic [NREQ*2-1:0]    req_arburst,
  input  logic [NREQ*3-1:0]    req_arprot,
  input  logic [NREQ*4-1:0]    req_arcache,
  input  logic [NREQ-1:0]      req_arvalid,
  output logic [NREQ-1:0]      req_arready,
  output logic [63:0]          req_rdata,
  output logic [1:0]           req_rresp,
  output logic                 req_rlast,
  output logic [NREQ-1:0]      req_rvalid,
  input  logic [NREQ-1:0]      req_rready,
  output logic [31:0]          m_araddr,
  output logic [3:0]           m_arlen,
  output logic [2:0]           m_arsize,
  output logic [1:0]           m_arburst,
  output logic [2:0]           m_arprot,
  output logic [3:0]           m_arcache,
  output logic                 m_arvalid,
  input  logic                 m_arready,
  input  logic [63:0]          m_rdata,
  input  logic [1:0]           m_rresp,
  input  logic                 m_rlast,
  input  logic                 m_rvalid,
  output logic                 m_rready,
  output logic [GW-1:0]        grant,
  output logic                 busy,
  output logic                 len_err,
  input  logic                 err_clr
);
  // state | meaning
  // IDLE  | pick next owner round-robin among asserted arvalid
  // ADDR  | owner's AR request forwarded downstream
  // DATA  | R beats routed to owner until the RLAST handshake
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t        state, state_next;
  logic [GW-1:0] last, sel, cand;
  logic          sel_found;
  logic [3:0]    beat_cnt;
  logic          ar_hs, r_hs, len_set;

  logic [31:0] araddr_a  [NREQ];
  logic [3:0]  arlen_a   [NREQ];
  logic [2:0]  arsize_a  [NREQ];
  logic [1:0]  arburst_a [NREQ];
  logic [2:0]  arprot_a  [NREQ];
  logic [3:0]  arcache_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign araddr_a[i]  = req_araddr[32*i +: 32];
    assign arlen_a[i]   = req_arlen[4*i +: 4];
    assign arsize_a[i]  = req_arsize[3*i +: 3];
    assign arburst_a[i] = req_arburst[2*i +: 2];
    assign arprot_a[i]  = req_arprot[3*i +: 3];
    assign arcache_a[i] = req_arcache[4*i +: 4];
  end

  // Scan last+1, last+2, ... so the previous owner has lowest priority.
  always_comb begin
    sel       = last;
    sel_found = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = GW'((int'(last) + k) % NREQ);
      if (!sel_found && req_arvalid[cand]) begin
        sel       = cand;
        sel_found = 1'b1;
      end
    end
  end

  assign ar_hs   = (state == ADDR) && req_arvalid[grant] && m_arready;
  assign r_hs    = (state == DATA) && m_rvalid && req_rready[grant];
  assign len_set = r_hs && (m_rlast == (beat_cnt != 4'd0));

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next  = state;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    req_arready = '0;
    req_rvalid  = '0;
    case (state)
      IDLE: if (sel_found) state_next = ADDR;
      ADDR: begin
        m_arvalid          = req_arvalid[grant];
        req_arready[grant] = m_arready;
        if (ar_hs) state_next = DATA;
      end
      DATA: begin
        m_rready          = req_rready[grant];
        req_rvalid[grant] = m_rvalid;
        if (r_hs && m_rlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter saturates at 0 on overrun; the burst still ends only on RLAST.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      grant    <= '0;
      last     <= GW'(NREQ - 1);
      beat_cnt <= '0;
      len_err  <= 1'b0;
    end else begin
      if (state == IDLE && sel_found) begin
        grant <= sel;
        last  <= sel;
      end
      if (ar_hs)                            beat_cnt <= m_arlen;
      else if (r_hs && beat_cnt != 4'd0)    beat_cnt <= beat_cnt - 4'd1;
      if (len_set)      len_err <= 1'b1;
      else if (err_clr) len_err <= 1'b0;
    end
  end

  assign m_araddr  = araddr_a[grant];
  assign m_arlen   = arlen_a[grant];
  assign m_arsize  = arsize_a[grant];
  assign m_arburst = arburst_a[grant];
  assign m_arprot  = arprot_a[grant];
  assign m_arcache = arcache_a[grant];

  assign req_rdata = m_rdata;
  assign req_rresp = m_rresp;
  assign req_rlast = m_rlast;
  assign busy      = (state != IDLE);

endmodule
